npc_exec_ctrl: RTL and testbench
================================

Name: npc_exec_ctrl

Overview:
Multi-cycle sequencer for the NPC RV32 datapath (PC register, register file, addi adder).
- Replaces the free-running pc+4 / always-write scheme with a fetch/execute FSM.
- Handshakes with instruction memory and latches the instruction.
- Drives register-file read and write ports, advances the PC only on retirement.
- Stops on ebreak, illegal instruction or fetch timeout.

Parameters:
- RESET_PC, 32'h80000000, PC value loaded on reset.
- FETCH_TIMEOUT, 16, max cycles waiting for imem_valid before the error stop (range 1..255).

Ports:
- clk  input  1  clock, all state changes on rising edge
- reset  input  1  synchronous, active-high
- imem_req  output  1  fetch request, held until accepted
- imem_addr  output  32  fetch address, equals pc
- imem_valid  input  1  instruction returned this cycle
- imem_rdata  input  32  instruction word, sampled when imem_req && imem_valid
- rf_raddr  output  5  register-file read address (rs1)
- rf_rdata  input  32  register-file read data, combinational from rf_raddr
- rf_waddr  output  5  register-file write address (rd)
- rf_wdata  output  32  register-file write data
- rf_wen  output  1  register-file write enable, one-cycle pulse
- pc  output  32  current program counter
- retire  output  1  one-cycle pulse per completed instruction
- halt  output  1  sticky, ebreak executed
- err  output  1  sticky, illegal instruction or fetch timeout

Behaviour:
- Reset (synchronous, active-high; overrides everything, including mid-fetch):
  - pc=RESET_PC, state=FETCH.
  - halt=0, err=0, rf_wen=0, retire=0, instruction register=0, timeout counter=0.
- States: FETCH, EXEC, HALT, ERR.
- FETCH:
  - imem_req=1, imem_addr=pc. Counter increments each cycle without imem_valid.
  - imem_valid=1: latch imem_rdata into ir, clear counter, go to EXEC. Valid in the first FETCH cycle is legal, so minimum latency is fetch 1 cycle + exec 1 cycle.
  - Counter reaches FETCH_TIMEOUT with no valid: err=1, go to ERR.
  - imem_valid while imem_req=0 is ignored.
- EXEC (exactly one cycle):
  - imem_req=0. Decode from ir only; imem_rdata is not used.
  - addi (ir[6:0]=7'b0010011, ir[14:12]=3'b000):
    - rf_raddr=ir[19:15], rf_waddr=ir[11:7].
    - rf_wdata=rf_rdata+sign-extended ir[31:20], modulo 2^32.
    - rf_wen=1 only if rd!=0.
    - retire=1, pc<=pc+4 (wraps at 2^32), next state FETCH.
  - ebreak (ir==32'h00100073): retire=1, halt=1, pc unchanged, go to HALT.
  - Any other encoding: err=1, no write, no retire, pc unchanged, go to ERR.
- Outside EXEC: rf_wen=0, retire=0, rf_raddr=0, rf_waddr=0, rf_wdata=0.
- HALT and ERR: terminal. imem_req=0, outputs frozen; only reset leaves them.
- halt and err are never both 1.

Optional Feature:
- Macro NPC_EXEC_INSTRET_EN.
- Defined:
  - Extra output port instret (32 bits), reset to 0.
  - Increments by 1 in each cycle retire=1, wraps at 2^32.
  - Holds in HALT and ERR.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset, then release with imem_valid=0 -> pc=80000000, imem_req=1, imem_addr=80000000, halt=err=0, rf_wen=0.
- Fetch 00500093 (addi x1,x0,5) with valid 2 cycles after req; rf_rdata=0 -> EXEC cycle shows rf_wen=1, rf_waddr=1, rf_wdata=5, retire=1; pc=80000004 next cycle; imem_req reasserted.
- Fetch FFF08113 (addi x2,x1,-1) with rf_rdata=0 for rs1=1 -> rf_raddr=1, rf_waddr=2, rf_wdata=FFFFFFFF. Fetch 00100013 (addi x0,x0,1) -> rf_wen=0, retire=1, pc advances.
- Fetch 00100073 -> retire=1, halt=1, pc stays; later imem_valid pulses -> imem_req=0, nothing changes. Fetch 00000000 -> err=1, retire=0, rf_wen=0.
- Hold imem_valid=0 for 16 cycles in FETCH -> err=1 on the 16th cycle. Assert reset during FETCH wait -> next cycle pc=80000000, counter=0, err=0. With NPC_EXEC_INSTRET_EN defined, 3 addi then ebreak -> instret=4.

Source files
------------

// File: rtl/npc_exec_ctrl.sv
// Fetch/execute sequencer for the NPC RV32 datapath (addi + ebreak).
// Optional NPC_EXEC_INSTRET_EN adds a 32-bit retired-instruction counter.
module npc_exec_ctrl #(
    parameter logic [31:0] RESET_PC      = 32'h80000000,
    parameter int          FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [4:0]  rf_raddr,
    input  logic [31:0] rf_rdata,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        rf_wen,
    output logic [31:0] pc,
    output logic        retire,
    output logic        halt,
    output logic        err
`ifdef NPC_EXEC_INSTRET_EN
    ,
    output logic [31:0] instret
`endif
);

    typedef enum logic [1:0] {
        FETCH,
        EXEC,
        HALT,
        ERR
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(FETCH_TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [31:0] ir;
    logic [7:0]  cnt, cnt_nxt;
    logic        ir_load;
    logic        pc_inc;
    logic        halt_set;
    logic        err_set;

    logic        is_addi;
    logic        is_ebreak;
    logic [31:0] imm;

    assign is_addi   = (ir[6:0] == 7'b0010011) && (ir[14:12] == 3'b000);
    assign is_ebreak = (ir == 32'h00100073);
    assign imm       = {{20{ir[31]}}, ir[31:20]};
    assign imem_addr = pc;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ir_load   = 1'b0;
        pc_inc    = 1'b0;
        halt_set  = 1'b0;
        err_set   = 1'b0;
        imem_req  = 1'b0;
        rf_raddr  = 5'd0;
        rf_waddr  = 5'd0;
        rf_wdata  = 32'd0;
        rf_wen    = 1'b0;
        retire    = 1'b0;
        case (state)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    ir_load   = 1'b1;
                    cnt_nxt   = 8'd0;
                    state_nxt = EXEC;
                end else if (cnt == CNT_LAST) begin
                    err_set   = 1'b1;
                    state_nxt = ERR;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            EXEC: begin
                unique case (1'b1)
                    is_addi: begin
                        rf_raddr  = ir[19:15];
                        rf_waddr  = ir[11:7];
                        rf_wdata  = rf_rdata + imm;
                        rf_wen    = (ir[11:7] != 5'd0);
                        retire    = 1'b1;
                        pc_inc    = 1'b1;
                        state_nxt = FETCH;
                    end
                    is_ebreak: begin
                        retire    = 1'b1;
                        halt_set  = 1'b1;
                        state_nxt = HALT;
                    end
                    default: begin
                        err_set   = 1'b1;
                        state_nxt = ERR;
                    end
                endcase
            end
            default: state_nxt = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            pc    <= RESET_PC;
            ir    <= 32'd0;
            cnt   <= 8'd0;
            halt  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (ir_load)  ir   <= imem_rdata;
            if (pc_inc)   pc   <= pc + 32'd4;
            if (halt_set) halt <= 1'b1;
            if (err_set)  err  <= 1'b1;
        end
    end

`ifdef NPC_EXEC_INSTRET_EN
    always_ff @(posedge clk) begin
        if (reset)       instret <= 32'd0;
        else if (retire) instret <= instret + 32'd1;
    end
`endif

endmodule

// File: tb/tb_npc_exec_ctrl.sv
// Directed self-checking bench for npc_exec_ctrl.
// Covers addi, ebreak, illegal decode, fetch timeout and reset.
module tb_npc_exec_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, w_imem_req;
    logic [31:0] imem_addr, w_imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [4:0]  rf_raddr, w_rf_raddr;
    logic [31:0] rf_rdata;
    logic [4:0]  rf_waddr, w_rf_waddr;
    logic [31:0] rf_wdata, w_rf_wdata;
    logic        rf_wen, w_rf_wen;
    logic [31:0] pc, w_pc;
    logic        retire, w_retire;
    logic        halt, w_halt;
    logic        err, w_err;
`ifdef NPC_EXEC_INSTRET_EN
    logic [31:0] instret, w_instret;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    npc_exec_ctrl dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_wen(rf_wen), .pc(pc), .retire(retire),
        .halt(halt), .err(err)
`ifdef NPC_EXEC_INSTRET_EN
        , .instret(instret)
`endif
    );

    npc_exec_ctrl #(.RESET_PC(32'hFFFFFFFC)) u_wrap (
        .clk(clk), .reset(reset),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .rf_raddr(w_rf_raddr), .rf_rdata(rf_rdata),
        .rf_waddr(w_rf_waddr), .rf_wdata(w_rf_wdata),
        .rf_wen(w_rf_wen), .pc(w_pc), .retire(w_retire),
        .halt(w_halt), .err(w_err)
`ifdef NPC_EXEC_INSTRET_EN
        , .instret(w_instret)
`endif
    );

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        imem_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Leaves the bench at the negedge of the EXEC cycle, inputs settled.
    task automatic fetch(input logic [31:0] instr, input int delay);
        for (int i = 0; i < delay; i++) begin
            imem_valid = 1'b0;
            @(negedge clk);
        end
        imem_valid = 1'b1;
        imem_rdata = instr;
        @(negedge clk);
        imem_valid = 1'b0;
        imem_rdata = 32'hDEADBEEF;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        tests++; if (pc !== 32'h80000000) begin fails++; $display("FAIL reset_pc got %h exp 80000000", pc); end
        tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL reset_req got %b exp 1", imem_req); end
        tests++; if (imem_addr !== 32'h80000000) begin fails++; $display("FAIL reset_addr got %h exp 80000000", imem_addr); end
        tests++; if ({halt, err, rf_wen, retire} !== 4'b0000) begin fails++; $display("FAIL reset_flags got %b exp 0000", {halt, err, rf_wen, retire}); end
`ifdef NPC_EXEC_INSTRET_EN
        tests++; if (instret !== 32'd0) begin fails++; $display("FAIL reset_instret got %0d exp 0", instret); end
`endif
    endtask

    task automatic test_addi();
        rf_rdata = 32'd0;
        fetch(32'h00500093, 2);
        tests++; if ({rf_wen, retire, imem_req} !== 3'b110) begin fails++; $display("FAIL addi_ctl got %b exp 110", {rf_wen, retire, imem_req}); end
        tests++; if (rf_waddr !== 5'd1) begin fails++; $display("FAIL addi_waddr got %0d exp 1", rf_waddr); end
        tests++; if (rf_wdata !== 32'd5) begin fails++; $display("FAIL addi_wdata got %h exp 5", rf_wdata); end
        tests++; if (pc !== 32'h80000000) begin fails++; $display("FAIL addi_pc_exec got %h exp 80000000", pc); end
        @(negedge clk); #1;
        tests++; if (pc !== 32'h80000004) begin fails++; $display("FAIL addi_pc_next got %h exp 80000004", pc); end
        tests++; if ({imem_req, retire, rf_wen} !== 3'b100) begin fails++; $display("FAIL addi_refetch got %b exp 100", {imem_req, retire, rf_wen}); end
        tests++; if (w_pc !== 32'h00000000) begin fails++; $display("FAIL pc_wrap got %h exp 00000000", w_pc); end
    endtask

    task automatic test_addi_neg();
        rf_rdata = 32'd0;
        fetch(32'hFFF08113, 0);
        tests++; if (rf_raddr !== 5'd1) begin fails++; $display("FAIL neg_raddr got %0d exp 1", rf_raddr); end
        tests++; if (rf_waddr !== 5'd2) begin fails++; $display("FAIL neg_waddr got %0d exp 2", rf_waddr); end
        tests++; if (rf_wdata !== 32'hFFFFFFFF) begin fails++; $display("FAIL neg_wdata got %h exp FFFFFFFF", rf_wdata); end
        rf_rdata = 32'h00000010;
        #1;
        tests++; if (rf_wdata !== 32'h0000000F) begin fails++; $display("FAIL neg_carry got %h exp 0000000F", rf_wdata); end
        rf_rdata = 32'd0;
        @(negedge clk); #1;
        tests++; if (pc !== 32'h80000008) begin fails++; $display("FAIL neg_pc got %h exp 80000008", pc); end
        fetch(32'h00100013, 1);
        tests++; if ({rf_wen, retire} !== 2'b01) begin fails++; $display("FAIL x0_ctl got %b exp 01", {rf_wen, retire}); end
        @(negedge clk); #1;
        tests++; if (pc !== 32'h8000000C) begin fails++; $display("FAIL x0_pc got %h exp 8000000C", pc); end
    endtask

    task automatic test_ebreak();
        fetch(32'h00100073, 0);
        tests++; if ({retire, rf_wen} !== 2'b10) begin fails++; $display("FAIL ebreak_ctl got %b exp 10", {retire, rf_wen}); end
        @(negedge clk); #1;
        tests++; if ({halt, err, imem_req} !== 3'b100) begin fails++; $display("FAIL ebreak_state got %b exp 100", {halt, err, imem_req}); end
        tests++; if (pc !== 32'h8000000C) begin fails++; $display("FAIL ebreak_pc got %h exp 8000000C", pc); end
`ifdef NPC_EXEC_INSTRET_EN
        tests++; if (instret !== 32'd4) begin fails++; $display("FAIL instret got %0d exp 4", instret); end
`endif
        for (int i = 0; i < 4; i++) begin
            imem_valid = 1'b1;
            imem_rdata = 32'h00500093;
            @(negedge clk); #1;
        end
        imem_valid = 1'b0;
        tests++; if ({halt, err, imem_req, retire, rf_wen} !== 5'b10000) begin fails++; $display("FAIL halt_frozen got %b exp 10000", {halt, err, imem_req, retire, rf_wen}); end
        tests++; if (pc !== 32'h8000000C) begin fails++; $display("FAIL halt_pc got %h exp 8000000C", pc); end
`ifdef NPC_EXEC_INSTRET_EN
        tests++; if (instret !== 32'd4) begin fails++; $display("FAIL instret_hold got %0d exp 4", instret); end
`endif
    endtask

    task automatic test_illegal();
        do_reset();
        fetch(32'h00000000, 0);
        tests++; if ({retire, rf_wen} !== 2'b00) begin fails++; $display("FAIL illegal_ctl got %b exp 00", {retire, rf_wen}); end
        @(negedge clk); #1;
        tests++; if ({err, halt, imem_req} !== 3'b100) begin fails++; $display("FAIL illegal_state got %b exp 100", {err, halt, imem_req}); end
        tests++; if (pc !== 32'h80000000) begin fails++; $display("FAIL illegal_pc got %h exp 80000000", pc); end
    endtask

    task automatic test_timeout();
        do_reset();
        imem_valid = 1'b0;
        for (int i = 0; i < 15; i++) @(negedge clk);
        #1;
        tests++; if ({err, imem_req} !== 2'b01) begin fails++; $display("FAIL timeout_15 got %b exp 01", {err, imem_req}); end
        @(negedge clk); #1;
        tests++; if ({err, imem_req} !== 2'b10) begin fails++; $display("FAIL timeout_16 got %b exp 10", {err, imem_req}); end
    endtask

    task automatic test_reset_mid_fetch();
        do_reset();
        imem_valid = 1'b0;
        for (int i = 0; i < 10; i++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests++; if ({err, imem_req} !== 2'b01) begin fails++; $display("FAIL midrst_state got %b exp 01", {err, imem_req}); end
        tests++; if (pc !== 32'h80000000) begin fails++; $display("FAIL midrst_pc got %h exp 80000000", pc); end
        for (int i = 0; i < 15; i++) @(negedge clk);
        #1;
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL midrst_cnt15 got %b exp 0", err); end
        @(negedge clk); #1;
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL midrst_cnt16 got %b exp 1", err); end
    endtask

    initial begin
        reset = 1'b1;
        imem_valid = 1'b0;
        imem_rdata = 32'd0;
        rf_rdata = 32'd0;
        test_reset();
        test_addi();
        test_addi_neg();
        test_ebreak();
        test_illegal();
        test_timeout();
        test_reset_mid_fetch();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
